gate_sweep_sequencer: RTL and testbench
=======================================

Name: gate_sweep_sequencer

Overview:
- Self-checking sequencer for a small switch-level gate cell (NAND/NOR/etc.) on silicon or in simulation.
- On a start pulse it walks the gate inputs through every input combination, ascending from 0.
- For each combination it holds the vector for a programmable settle time, then samples the gate output and compares it to a parameterised expected truth table.
- It reports the mismatch count, the observed truth table, and a pass/fail flag; it is the synthesizable replacement for ad-hoc delay-based stimulus loops.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..4; number of vectors NV = 2^N_IN.
- SETTLE, 5, clock cycles the vector is held before the sample cycle; must be >= 1.
- TRUTH, 4'b0111, expected output, NV bits wide; bit i is the expected output for vec == i. The default is a 2-input NAND with vec = {x,y}.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- gate_out  input  1  output of the gate under test.
- vec  output  N_IN  drives the gate inputs; the MSB maps to the first gate input (x).
- busy  output  1  high while a sweep is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start.
- err_cnt  output  N_IN+1  mismatch count of the current or last sweep.
- obs  output  NV  observed truth table; bit i is the gate_out sampled for vec == i.

Behaviour:
- All outputs are registered.
- On rst: state IDLE; vec, busy, done, pass, err_cnt, obs and the internal idx/cnt all = 0. Reset overrides everything, including mid-sweep; any partial results are discarded.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - When start = 1 at edge E0: vec <= 0, cnt <= 0, err_cnt <= 0, obs <= 0, pass <= 0, busy <= 1, go to SETTLE.
  - When start = 0: all outputs hold their values, including vec, pass, err_cnt and obs from the previous sweep.
- SETTLE:
  - If cnt == SETTLE-1, go to SAMPLE; otherwise cnt <= cnt+1.
- SAMPLE (exactly one cycle):
  - At the leaving edge: obs[idx] <= gate_out; if gate_out != TRUTH[idx], err_cnt <= err_cnt+1.
  - If idx == NV-1, go to DONE. Otherwise idx <= idx+1, vec <= idx+1, cnt <= 0, go to SETTLE.
- Vector timing:
  - Each vector is held for exactly SETTLE+1 cycles.
  - The final sample edge is E0 + NV*(SETTLE+1); with defaults this is E24.
- DONE:
  - done = 1 for exactly one cycle.
  - pass = (final err_cnt == 0), registered on entry to DONE, so it is valid in the same cycle as done.
  - On the next edge: busy <= 0, done <= 0, go to IDLE.
- start while busy (SETTLE/SAMPLE/DONE) is ignored; there is no queuing.
- start asserted in the first IDLE cycle after DONE is accepted, giving back-to-back sweeps.
- After a sweep, vec holds the last applied vector (NV-1) until the next start.
- err_cnt cannot wrap: its maximum is NV, and it is N_IN+1 bits wide.
- gate_out is sampled only in SAMPLE; its value in every other state is ignored.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE.
  - err_cnt = 1 and pass = 0.
  - vec holds the failing vector after the sweep.
  - obs bits for vectors not yet sampled remain 0.
- Undefined: the full sweep always runs, and err_cnt is the total number of mismatches.

Test Plan:
- Ideal NAND model (gate_out = ~(vec[1]&vec[0])), defaults, start at E0 -> vec steps 0,1,2,3 every 6 cycles; done high only in the cycle after E24; pass = 1, err_cnt = 0, obs = 4'b0111, busy low after E25.
- gate_out stuck at 1, macro undefined -> done after E24; err_cnt = 1, obs = 4'b1111, pass = 0.
- gate_out stuck at 0, macro undefined -> err_cnt = 3, obs = 4'b0000; with macro defined -> done after E6, err_cnt = 1, vec = 0, pass = 0.
- start pulsed at E3 and E10 during a sweep -> ignored; done still occurs only after E24, and no second sweep starts.
- rst asserted at E14 (vec = 2) -> at the next edge all outputs = 0 and state is IDLE; a start two cycles later runs a clean full sweep with pass = 1.
- start held high continuously with the ideal model -> sweeps restart the cycle after each DONE; err_cnt and obs are cleared at each restart; done pulses every 26 cycles.

Source files
------------

// File: rtl/gate_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// gate_sweep_sequencer
//
// Purpose:
//   Self-checking stimulus sequencer for a small gate cell. A start pulse
//   launches a sweep. The sweep drives every input vector in ascending order
//   from 0. Each vector is held for SETTLE cycles, then the gate output is
//   sampled for one cycle and compared against the expected truth table TRUTH.
//   The mismatch count, the observed truth table and a pass flag are reported.
//
// Parameters:
//   N_IN    number of gate inputs (1..4); NV = 2**N_IN vectors
//   SETTLE  hold cycles before the sample cycle (>= 1)
//   TRUTH   expected output table, bit i is the expected gate_out for vec == i
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin a sweep (only looked at while idle)
//   gate_out  in   output of the gate under test
//   vec       out  gate input vector, MSB is the first gate input
//   busy      out  sweep in progress, including the done cycle
//   done      out  one-cycle pulse at the end of a sweep
//   pass      out  last sweep had zero mismatches, valid with done
//   err_cnt   out  mismatch count of the current or last sweep
//   obs       out  observed truth table, bit i sampled for vec == i
//
// Optional feature:
//   GATE_SWEEP_STOP_ON_FAIL_EN - when defined, the first mismatch ends the
//   sweep immediately. vec then holds the failing vector, and obs bits for
//   vectors that were never sampled remain 0.
// -----------------------------------------------------------------------------
module gate_sweep_sequencer #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 5,
    parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b0111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   gate_out,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_cnt,
    output logic [(1<<N_IN)-1:0]   obs
);

    localparam int NV    = 1 << N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(NV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_nxt;
    logic [N_IN-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_IN-1:0]   vec_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              pass_nxt;
    logic [N_IN:0]     err_nxt;
    logic [NV-1:0]     obs_nxt;
    logic              mismatch;
    logic              sweep_end;

    // State and registered outputs. Everything is cleared on reset, so a
    // sweep that is interrupted mid-way leaves no partial results behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            vec     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            obs     <= '0;
        end else begin
            state_q <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            vec     <= vec_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pass    <= pass_nxt;
            err_cnt <= err_nxt;
            obs     <= obs_nxt;
        end
    end

    // Next-state and next-output logic. Every register holds its value by
    // default. The only exception is done, which is a pulse.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
        err_nxt   = err_cnt;
        obs_nxt   = obs;
        mismatch  = 1'b0;
        sweep_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    vec_nxt   = '0;
                    err_nxt   = '0;
                    obs_nxt   = '0;
                    pass_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                obs_nxt[idx] = gate_out;
                mismatch     = (gate_out != TRUTH[idx]);
                if (mismatch) begin
                    err_nxt = err_cnt + (N_IN + 1)'(1);
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                sweep_end = mismatch || (idx == IDX_LAST);
`else
                sweep_end = (idx == IDX_LAST);
`endif
                if (sweep_end) begin
                    // pass is computed from the updated count, so it is
                    // valid in the same cycle as done.
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = S_DONE;
                end else begin
                    // idx cannot overflow here because the last index
                    // leaves through the branch above.
                    idx_nxt   = idx + N_IN'(1);
                    vec_nxt   = idx + N_IN'(1);
                    cnt_nxt   = '0;
                    state_nxt = S_SETTLE;
                end
            end

            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_sequencer
//
// Purpose:
//   Randomized self-checking bench for gate_sweep_sequencer with its default
//   parameters. A reference model tracks the expected outputs sweep by sweep.
//   The model works from the vector timing (SETTLE+1 cycles per vector, with
//   the sample on the last edge) and from a per-sweep gate table. It checks
//   the outputs on every cycle.
//
// Ports: none (top-level bench).
//
// Optional feature:
//   GATE_SWEEP_STOP_ON_FAIL_EN - the model ends a sweep at the first mismatch
//   when this macro is defined.
// -----------------------------------------------------------------------------
module tb_gate_sweep_sequencer;

    localparam int          N_IN   = 2;
    localparam int          SETTLE = 5;
    localparam int          NV     = 1 << N_IN;
    localparam logic [3:0]  TRUTH  = 4'b0111;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             gate_out;
    logic [N_IN-1:0]  vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_cnt;
    logic [NV-1:0]    obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected held output values
    logic [N_IN-1:0]  m_vec  = '0;
    logic [N_IN:0]    m_err  = '0;
    logic [NV-1:0]    m_obs  = '0;
    logic             m_pass = 1'b0;

    gate_sweep_sequencer #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE),
        .TRUTH  (TRUTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gate_out (gate_out),
        .vec      (vec),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .obs      (obs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic busy_e, input logic done_e);
        chk({tag, ":vec"},  32'(vec),     32'(m_vec));
        chk({tag, ":busy"}, 32'(busy),    32'(busy_e));
        chk({tag, ":done"}, 32'(done),    32'(done_e));
        chk({tag, ":pass"}, 32'(pass),    32'(m_pass));
        chk({tag, ":err"},  32'(err_cnt), 32'(m_err));
        chk({tag, ":obs"},  32'(obs),     32'(m_obs));
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: quiet inputs; mode 1: random start pulses and gate noise outside
    // the sample edge; mode 2: start held high throughout.
    function automatic logic start_val(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic run_sweep(input logic [NV-1:0] table_v, input int mode);
        bit stop;
        stop     = 1'b0;
        start    = 1'b1;
        gate_out = 1'($urandom_range(0, 1));
        tick();
        m_vec  = '0;
        m_err  = '0;
        m_obs  = '0;
        m_pass = 1'b0;
        check_all("start", 1'b1, 1'b0);
        for (int k = 0; k < NV && !stop; k++) begin
            for (int c = 0; c <= SETTLE; c++) begin
                start = start_val(mode);
                if (c == SETTLE)
                    gate_out = table_v[k];
                else if (mode == 1)
                    gate_out = 1'($urandom_range(0, 1));
                else
                    gate_out = table_v[k];
                tick();
                if (c < SETTLE) check_all("hold_vec", 1'b1, 1'b0);
            end
            m_obs[k] = table_v[k];
            if (table_v[k] != TRUTH[k]) begin
                m_err = m_err + 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                stop = 1'b1;
`endif
            end
            if (k != NV - 1 && !stop) begin
                m_vec = N_IN'(k + 1);
                check_all("next_vec", 1'b1, 1'b0);
            end
        end
        m_pass = (m_err == 0);
        check_all("done", 1'b1, 1'b1);
        start    = start_val(mode);
        gate_out = 1'($urandom_range(0, 1));
        tick();
        check_all("post_done", 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            gate_out = 1'($urandom_range(0, 1));
            tick();
            check_all("idle_hold", 1'b0, 1'b0);
        end
    endtask

    // Start a sweep, run n more edges, then reset on the following edge.
    task automatic reset_mid(input int n);
        start = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            gate_out = 1'($urandom_range(0, 1));
            tick();
        end
        chk("pre_rst:busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_vec  = '0;
        m_err  = '0;
        m_obs  = '0;
        m_pass = 1'b0;
        check_all("mid_rst", 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        gate_out = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Ideal NAND, then stuck-at-1, then stuck-at-0
        run_sweep(TRUTH, 0);
        idle(3);
        run_sweep(4'b1111, 0);
        idle(2);
        run_sweep(4'b0000, 0);
        idle(2);

        // Start pulses and gate noise during a sweep must be ignored
        run_sweep(TRUTH, 1);
        idle(2);

        // Reset at E14 while vec == 2, then a clean sweep
        reset_mid(13);
        idle(1);
        run_sweep(TRUTH, 0);

        // Start held high: sweeps run back to back
        run_sweep(TRUTH, 2);
        run_sweep(TRUTH, 2);
        run_sweep(TRUTH, 2);
        idle(2);

        // Random tables and modes
        for (int s = 0; s < 30; s++) begin
            logic [NV-1:0] tv;
            tv = NV'($urandom);
            run_sweep(tv, int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
